// File: rtl/ros2_shared_resource_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ros2_shared_resource_arbiter_if - app_data / UDP RX ownership handshakes  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface ros2_shared_resource_arbiter_if;
    logic app_data_ip_req;
    logic app_data_ip_rel;
    logic app_data_cpu_req;
    logic app_data_cpu_rel;
    logic app_data_ip_grant;
    logic app_data_cpu_grant;
    logic udp_rxbuf_ip_rel;
    logic udp_rxbuf_cpu_rel;
    logic udp_rxbuf_ip_grant;
    logic udp_rxbuf_cpu_grant;
    logic udp_rxbuf_cpu_irq;
    logic timeout_clr;
    logic timeout_ip;
    logic timeout_cpu;

    modport master (
        output app_data_ip_req,
        output app_data_ip_rel,
        output app_data_cpu_req,
        output app_data_cpu_rel,
        output udp_rxbuf_ip_rel,
        output udp_rxbuf_cpu_rel,
        output timeout_clr,
        input  app_data_ip_grant,
        input  app_data_cpu_grant,
        input  udp_rxbuf_ip_grant,
        input  udp_rxbuf_cpu_grant,
        input  udp_rxbuf_cpu_irq,
        input  timeout_ip,
        input  timeout_cpu
    );

    modport slave (
        input  app_data_ip_req,
        input  app_data_ip_rel,
        input  app_data_cpu_req,
        input  app_data_cpu_rel,
        input  udp_rxbuf_ip_rel,
        input  udp_rxbuf_cpu_rel,
        input  timeout_clr,
        output app_data_ip_grant,
        output app_data_cpu_grant,
        output udp_rxbuf_ip_grant,
        output udp_rxbuf_cpu_grant,
        output udp_rxbuf_cpu_irq,
        output timeout_ip,
        output timeout_cpu
    );
endinterface
`default_nettype wire

// File: rtl/ros2_shared_resource_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ros2_shared_resource_arbiter - app_data round-robin + UDP RX handoff      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ros2_shared_resource_arbiter #(
    parameter int TIMEOUT_WIDTH = 20,
    parameter int HOLD_TIMEOUT  = 100000,
    parameter int GAP_CYCLES    = 1
) (
    input  wire logic                    clk_int,
    input  wire logic                    rst_int,
    ros2_shared_resource_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        APP_IDLE      = 2'd0,
        APP_GRANT_IP  = 2'd1,
        APP_GRANT_CPU = 2'd2,
        APP_GAP       = 2'd3
    } app_state_e;

    typedef enum logic {
        RX_OWN_IP  = 1'b0,
        RX_OWN_CPU = 1'b1
    } rx_state_e;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] c_GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TIMEOUT_WIDTH-1:0] c_HOLD_LAST = TIMEOUT_WIDTH'(HOLD_TIMEOUT - 1);
    localparam app_state_e c_LEAVE_STATE = (GAP_CYCLES > 0) ? APP_GAP : APP_IDLE;

    app_state_e               app_state_q;
    logic                     pend_ip_q;
    logic                     pend_cpu_q;
    logic                     last_cpu_q;
    logic [TIMEOUT_WIDTH-1:0] hold_cnt_q;
    logic [GAP_W-1:0]         gap_cnt_q;
    logic                     app_ip_grant_q;
    logic                     app_cpu_grant_q;
    logic                     timeout_ip_q;
    logic                     timeout_cpu_q;

    rx_state_e                rx_state_q;
    logic                     rx_ip_grant_q;
    logic                     rx_cpu_grant_q;
    logic                     rx_irq_q;

    logic w_eff_ip;
    logic w_eff_cpu;
    logic w_expire;
    logic w_to_ip;
    logic w_to_cpu;

    assign w_eff_ip  = pend_ip_q  | bus.app_data_ip_req;
    assign w_eff_cpu = pend_cpu_q | bus.app_data_cpu_req;

    // A release on the expiry edge wins, so the watchdog flag only fires without one.
    assign w_expire = (HOLD_TIMEOUT != 0) && (hold_cnt_q == c_HOLD_LAST);
    assign w_to_ip  = (app_state_q == APP_GRANT_IP)  && w_expire && !bus.app_data_ip_rel;
    assign w_to_cpu = (app_state_q == APP_GRANT_CPU) && w_expire && !bus.app_data_cpu_rel;

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            app_state_q     <= APP_IDLE;
            pend_ip_q       <= 1'b0;
            pend_cpu_q      <= 1'b0;
            last_cpu_q      <= 1'b1;
            hold_cnt_q      <= '0;
            gap_cnt_q       <= '0;
            app_ip_grant_q  <= 1'b0;
            app_cpu_grant_q <= 1'b0;
            timeout_ip_q    <= 1'b0;
            timeout_cpu_q   <= 1'b0;
        end else begin
            timeout_ip_q  <= (timeout_ip_q  & ~bus.timeout_clr) | w_to_ip;
            timeout_cpu_q <= (timeout_cpu_q & ~bus.timeout_clr) | w_to_cpu;

            case (app_state_q)
                APP_IDLE: begin
                    // On a tie the requester that did not own the buffer last wins.
                    if (w_eff_ip && (!w_eff_cpu || last_cpu_q)) begin
                        app_state_q    <= APP_GRANT_IP;
                        app_ip_grant_q <= 1'b1;
                        pend_ip_q      <= 1'b0;
                        pend_cpu_q     <= w_eff_cpu;
                        hold_cnt_q     <= '0;
                    end else if (w_eff_cpu) begin
                        app_state_q     <= APP_GRANT_CPU;
                        app_cpu_grant_q <= 1'b1;
                        pend_cpu_q      <= 1'b0;
                        pend_ip_q       <= w_eff_ip;
                        hold_cnt_q      <= '0;
                    end
                end

                APP_GRANT_IP: begin
                    pend_cpu_q <= pend_cpu_q | bus.app_data_cpu_req;
                    if (bus.app_data_ip_rel || w_expire) begin
                        app_state_q    <= c_LEAVE_STATE;
                        app_ip_grant_q <= 1'b0;
                        last_cpu_q     <= 1'b0;
                        gap_cnt_q      <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end

                APP_GRANT_CPU: begin
                    pend_ip_q <= pend_ip_q | bus.app_data_ip_req;
                    if (bus.app_data_cpu_rel || w_expire) begin
                        app_state_q     <= c_LEAVE_STATE;
                        app_cpu_grant_q <= 1'b0;
                        last_cpu_q      <= 1'b1;
                        gap_cnt_q       <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end

                APP_GAP: begin
                    pend_ip_q  <= pend_ip_q  | bus.app_data_ip_req;
                    pend_cpu_q <= pend_cpu_q | bus.app_data_cpu_req;
                    if (gap_cnt_q == c_GAP_LAST) begin
                        app_state_q <= APP_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                default: begin
                    app_state_q     <= APP_IDLE;
                    app_ip_grant_q  <= 1'b0;
                    app_cpu_grant_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            rx_state_q     <= RX_OWN_IP;
            rx_ip_grant_q  <= 1'b1;
            rx_cpu_grant_q <= 1'b0;
            rx_irq_q       <= 1'b0;
        end else begin
            rx_irq_q <= 1'b0;
            case (rx_state_q)
                RX_OWN_IP: begin
                    if (bus.udp_rxbuf_ip_rel) begin
                        rx_state_q     <= RX_OWN_CPU;
                        rx_ip_grant_q  <= 1'b0;
                        rx_cpu_grant_q <= 1'b1;
                        rx_irq_q       <= 1'b1;
                    end
                end
                RX_OWN_CPU: begin
                    if (bus.udp_rxbuf_cpu_rel) begin
                        rx_state_q     <= RX_OWN_IP;
                        rx_ip_grant_q  <= 1'b1;
                        rx_cpu_grant_q <= 1'b0;
                    end
                end
                default: begin
                    rx_state_q     <= RX_OWN_IP;
                    rx_ip_grant_q  <= 1'b1;
                    rx_cpu_grant_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.app_data_ip_grant   = app_ip_grant_q;
    assign bus.app_data_cpu_grant  = app_cpu_grant_q;
    assign bus.udp_rxbuf_ip_grant  = rx_ip_grant_q;
    assign bus.udp_rxbuf_cpu_grant = rx_cpu_grant_q;
    assign bus.udp_rxbuf_cpu_irq   = rx_irq_q;
    assign bus.timeout_ip          = timeout_ip_q;
    assign bus.timeout_cpu         = timeout_cpu_q;

endmodule
`default_nettype wire

// File: tb/tb_ros2_shared_resource_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ros2_shared_resource_arbiter - scenario tasks + behavioural model      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ros2_shared_resource_arbiter;

    localparam int HOLD = 16;
    localparam int GAP  = 1;

    // Stimulus word: {ip_req, ip_rel, cpu_req, cpu_rel, rx_ip_rel, rx_cpu_rel, clr}
    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_IPQ   = 7'b1000000;
    localparam logic [6:0] I_IPREL = 7'b0100000;
    localparam logic [6:0] I_CPQ   = 7'b0010000;
    localparam logic [6:0] I_CPREL = 7'b0001000;
    localparam logic [6:0] I_RXIP  = 7'b0000100;
    localparam logic [6:0] I_RXCPU = 7'b0000010;
    localparam logic [6:0] I_CLR   = 7'b0000001;

    // Output word: {ip_grant, cpu_grant, rx_ip_grant, rx_cpu_grant, irq, to_ip, to_cpu}
    localparam logic [6:0] RESET_OUT = 7'b0010000;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ros2_shared_resource_arbiter_if bus ();
    ros2_shared_resource_arbiter_if bus2 ();

    ros2_shared_resource_arbiter #(
        .TIMEOUT_WIDTH (20),
        .HOLD_TIMEOUT  (HOLD),
        .GAP_CYCLES    (GAP)
    ) u_dut (
        .clk_int (clk),
        .rst_int (rst),
        .bus     (bus)
    );

    ros2_shared_resource_arbiter #(
        .TIMEOUT_WIDTH (20),
        .HOLD_TIMEOUT  (0),
        .GAP_CYCLES    (0)
    ) u_dut_nogap (
        .clk_int (clk),
        .rst_int (rst),
        .bus     (bus2)
    );

    logic [6:0] obs;
    assign obs = {bus.app_data_ip_grant, bus.app_data_cpu_grant, bus.udp_rxbuf_ip_grant,
                  bus.udp_rxbuf_cpu_grant, bus.udp_rxbuf_cpu_irq, bus.timeout_ip,
                  bus.timeout_cpu};

    // Behavioural model: owner 0=nobody 1=IP 2=CPU; gap_left counts remaining dead cycles.
    int m_owner, m_gap_left, m_held, m_last;
    bit m_pend_ip, m_pend_cpu, m_to_ip, m_to_cpu, m_rx_cpu, m_irq;

    task automatic model_reset();
        m_owner = 0; m_gap_left = 0; m_held = 0; m_last = 2;
        m_pend_ip = 0; m_pend_cpu = 0; m_to_ip = 0; m_to_cpu = 0;
        m_rx_cpu = 0; m_irq = 0;
    endtask

    function automatic logic [6:0] model_vec();
        return {logic'(m_owner == 1), logic'(m_owner == 2), logic'(!m_rx_cpu),
                logic'(m_rx_cpu), logic'(m_irq), logic'(m_to_ip), logic'(m_to_cpu)};
    endfunction

    task automatic model_step(input logic [6:0] v);
        bit e_ip, e_cpu, own_rel, ev_ip, ev_cpu;
        int winner;
        ev_ip = 0; ev_cpu = 0;
        if (m_owner == 0 && m_gap_left == 0) begin
            e_ip  = m_pend_ip  || v[6];
            e_cpu = m_pend_cpu || v[4];
            if (e_ip && e_cpu) winner = (m_last == 2) ? 1 : 2;
            else if (e_ip)     winner = 1;
            else if (e_cpu)    winner = 2;
            else               winner = 0;
            if (winner != 0) begin
                m_owner    = winner;
                m_held     = 0;
                m_pend_ip  = (winner == 1) ? 1'b0 : e_ip;
                m_pend_cpu = (winner == 2) ? 1'b0 : e_cpu;
            end
        end else if (m_owner == 0) begin
            m_pend_ip  = m_pend_ip  || v[6];
            m_pend_cpu = m_pend_cpu || v[4];
            m_gap_left = m_gap_left - 1;
        end else begin
            own_rel = (m_owner == 1) ? v[5] : v[3];
            if (m_owner == 1) m_pend_cpu = m_pend_cpu || v[4];
            else              m_pend_ip  = m_pend_ip  || v[6];
            m_held = m_held + 1;
            if (own_rel || m_held == HOLD) begin
                if (!own_rel) begin
                    if (m_owner == 1) ev_ip = 1; else ev_cpu = 1;
                end
                m_last     = m_owner;
                m_owner    = 0;
                m_gap_left = GAP;
            end
        end
        m_to_ip  = (m_to_ip  && !v[0]) || ev_ip;
        m_to_cpu = (m_to_cpu && !v[0]) || ev_cpu;
        m_irq    = !m_rx_cpu && v[2];
        if (!m_rx_cpu && v[2])     m_rx_cpu = 1;
        else if (m_rx_cpu && v[1]) m_rx_cpu = 0;
    endtask

    task automatic drive(input logic [6:0] v);
        bus.app_data_ip_req   = v[6];
        bus.app_data_ip_rel   = v[5];
        bus.app_data_cpu_req  = v[4];
        bus.app_data_cpu_rel  = v[3];
        bus.udp_rxbuf_ip_rel  = v[2];
        bus.udp_rxbuf_cpu_rel = v[1];
        bus.timeout_clr       = v[0];
    endtask

    task automatic drive2_zero();
        bus2.app_data_ip_req   = 1'b0;
        bus2.app_data_ip_rel   = 1'b0;
        bus2.app_data_cpu_req  = 1'b0;
        bus2.app_data_cpu_rel  = 1'b0;
        bus2.udp_rxbuf_ip_rel  = 1'b0;
        bus2.udp_rxbuf_cpu_rel = 1'b0;
        bus2.timeout_clr       = 1'b0;
    endtask

    // Called at a falling edge: drive, advance the model, wait to the next falling edge.
    task automatic tick(input logic [6:0] v);
        drive(v);
        model_step(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(I_NONE);
        drive2_zero();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (obs !== RESET_OUT) begin
            errors++; $display("FAIL reset_values: got %b expected %b", obs, RESET_OUT);
        end
        checks++;
        tick(I_NONE);
        if (obs !== RESET_OUT) begin
            errors++; $display("FAIL reset_idle: got %b expected %b", obs, RESET_OUT);
        end
        checks++;
    endtask

    task automatic test_single_request();
        do_reset();
        repeat (4) tick(I_NONE);
        tick(I_IPQ);
        if (obs[6:5] !== 2'b10) begin
            errors++; $display("FAIL single_grant: got %b expected 10", obs[6:5]);
        end
        checks++;
        repeat (3) tick(I_NONE);
        if (obs[6:5] !== 2'b10) begin
            errors++; $display("FAIL single_hold: got %b expected 10", obs[6:5]);
        end
        checks++;
        tick(I_IPREL);
        if (obs[6:5] !== 2'b00) begin
            errors++; $display("FAIL single_release: got %b expected 00", obs[6:5]);
        end
        checks++;
        tick(I_CPQ);
        if (obs[6:5] !== 2'b00) begin
            errors++; $display("FAIL single_gap: got %b expected 00", obs[6:5]);
        end
        checks++;
        tick(I_NONE);
        if (obs[6:5] !== 2'b01 || obs[1:0] !== 2'b00) begin
            errors++; $display("FAIL single_pending_grant: got %b expected 0100", {obs[6:5], obs[1:0]});
        end
        checks++;
        tick(I_CPREL);
        repeat (2) tick(I_NONE);
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(I_IPQ | I_CPQ);
        if (obs[6:5] !== 2'b10) begin
            errors++; $display("FAIL rr_first_ip: got %b expected 10", obs[6:5]);
        end
        checks++;
        tick(I_NONE);
        tick(I_IPREL);
        tick(I_NONE);
        if (obs[6:5] !== 2'b00) begin
            errors++; $display("FAIL rr_dead_cycles: got %b expected 00", obs[6:5]);
        end
        checks++;
        tick(I_NONE);
        if (obs[6:5] !== 2'b01) begin
            errors++; $display("FAIL rr_cpu_after_gap: got %b expected 01", obs[6:5]);
        end
        checks++;
        tick(I_CPREL);
        tick(I_NONE);
        tick(I_IPQ | I_CPQ);
        if (obs[6:5] !== 2'b10) begin
            errors++; $display("FAIL rr_ip_next: got %b expected 10", obs[6:5]);
        end
        checks++;
    endtask

    task automatic test_watchdog();
        int cnt;
        do_reset();
        tick(I_CPQ);
        cnt = 0;
        while (bus.app_data_cpu_grant === 1'b1 && cnt < 40) begin
            cnt++;
            tick(I_NONE);
        end
        if (cnt != HOLD) begin
            errors++; $display("FAIL wd_hold_cycles: got %0d expected %0d", cnt, HOLD);
        end
        checks++;
        if (obs[1:0] !== 2'b01) begin
            errors++; $display("FAIL wd_flag_set: got %b expected 01", obs[1:0]);
        end
        checks++;
        repeat (3) tick(I_NONE);
        if (obs[1:0] !== 2'b01) begin
            errors++; $display("FAIL wd_flag_sticky: got %b expected 01", obs[1:0]);
        end
        checks++;
        tick(I_CLR);
        if (obs[1:0] !== 2'b00) begin
            errors++; $display("FAIL wd_flag_clear: got %b expected 00", obs[1:0]);
        end
        checks++;
        tick(I_IPQ);
        repeat (HOLD - 1) tick(I_NONE);
        tick(I_CLR);
        if ({obs[6], obs[1:0]} !== 3'b010) begin
            errors++; $display("FAIL wd_set_beats_clr: got %b expected 010", {obs[6], obs[1:0]});
        end
        checks++;
    endtask

    task automatic test_edge_cases();
        logic seen;
        do_reset();
        tick(I_IPQ);
        repeat (HOLD - 1) tick(I_NONE);
        tick(I_IPREL);
        if ({obs[6], obs[1:0]} !== 3'b000) begin
            errors++; $display("FAIL edge_rel_at_timeout: got %b expected 000", {obs[6], obs[1:0]});
        end
        checks++;
        tick(I_NONE);
        tick(I_IPQ);
        tick(I_IPQ);
        tick(I_CPREL);
        if (obs[6:5] !== 2'b10) begin
            errors++; $display("FAIL edge_nonowner_rel: got %b expected 10", obs[6:5]);
        end
        checks++;
        tick(I_IPREL);
        seen = 1'b0;
        repeat (5) begin
            tick(I_NONE);
            seen = seen | obs[6];
        end
        if (seen !== 1'b0) begin
            errors++; $display("FAIL edge_owner_req_ignored: got %b expected 0", seen);
        end
        checks++;
    endtask

    task automatic test_rx_handoff();
        do_reset();
        tick(I_RXIP);
        if (obs[4:2] !== 3'b011) begin
            errors++; $display("FAIL rx_to_cpu: got %b expected 011", obs[4:2]);
        end
        checks++;
        tick(I_RXIP);
        if (obs[4:2] !== 3'b010) begin
            errors++; $display("FAIL rx_second_ip_rel: got %b expected 010", obs[4:2]);
        end
        checks++;
        tick(I_RXCPU);
        if (obs[4:2] !== 3'b100) begin
            errors++; $display("FAIL rx_return: got %b expected 100", obs[4:2]);
        end
        checks++;
        tick(I_RXIP | I_RXCPU);
        if (obs[4:2] !== 3'b011) begin
            errors++; $display("FAIL rx_both_rel_ip_owner: got %b expected 011", obs[4:2]);
        end
        checks++;
        tick(I_RXIP | I_RXCPU);
        if (obs[4:2] !== 3'b100) begin
            errors++; $display("FAIL rx_both_rel_cpu_owner: got %b expected 100", obs[4:2]);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(I_IPQ | I_RXIP);
        tick(I_CPQ);
        if ({obs[6], obs[3]} !== 2'b11) begin
            errors++; $display("FAIL mid_setup: got %b expected 11", {obs[6], obs[3]});
        end
        checks++;
        rst = 1'b1;
        #1;
        if (obs !== RESET_OUT) begin
            errors++; $display("FAIL mid_async_reset: got %b expected %b", obs, RESET_OUT);
        end
        checks++;
        drive(I_NONE);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick(I_NONE);
        if (obs[6:5] !== 2'b00) begin
            errors++; $display("FAIL mid_pending_lost: got %b expected 00", obs[6:5]);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus2.app_data_cpu_req = 1'b1;
        @(negedge clk);
        bus2.app_data_cpu_req = 1'b0;
        if (bus2.app_data_cpu_grant !== 1'b1) begin
            errors++; $display("FAIL b2b_cpu_grant: got %b expected 1", bus2.app_data_cpu_grant);
        end
        checks++;
        repeat (40) @(negedge clk);
        if ({bus2.app_data_cpu_grant, bus2.timeout_cpu} !== 2'b10) begin
            errors++; $display("FAIL b2b_no_watchdog: got %b expected 10",
                               {bus2.app_data_cpu_grant, bus2.timeout_cpu});
        end
        checks++;
        bus2.app_data_ip_req = 1'b1;
        @(negedge clk);
        bus2.app_data_ip_req  = 1'b0;
        bus2.app_data_cpu_rel = 1'b1;
        @(negedge clk);
        bus2.app_data_cpu_rel = 1'b0;
        if ({bus2.app_data_ip_grant, bus2.app_data_cpu_grant} !== 2'b00) begin
            errors++; $display("FAIL b2b_idle_cycle: got %b expected 00",
                               {bus2.app_data_ip_grant, bus2.app_data_cpu_grant});
        end
        checks++;
        @(negedge clk);
        if ({bus2.app_data_ip_grant, bus2.app_data_cpu_grant} !== 2'b10) begin
            errors++; $display("FAIL b2b_grant_t2: got %b expected 10",
                               {bus2.app_data_ip_grant, bus2.app_data_cpu_grant});
        end
        checks++;
    endtask

    task automatic test_random();
        logic [6:0] v;
        logic [6:0] exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v[6] = ($urandom_range(0, 5) == 0);
            v[5] = ($urandom_range(0, 9) == 0);
            v[4] = ($urandom_range(0, 5) == 0);
            v[3] = ($urandom_range(0, 9) == 0);
            v[2] = ($urandom_range(0, 4) == 0);
            v[1] = ($urandom_range(0, 4) == 0);
            v[0] = ($urandom_range(0, 19) == 0);
            tick(v);
            exp = model_vec();
            if (obs !== exp) begin
                errors++; $display("FAIL random_cycle_%0d: got %b expected %b", i, obs, exp);
            end
            checks++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(I_NONE);
        drive2_zero();
        model_reset();
        test_reset();
        test_single_request();
        test_simultaneous();
        test_watchdog();
        test_edge_cases();
        test_rx_handoff();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire

// File: doc/ros2_shared_resource_arbiter.md
Name: ros2_shared_resource_arbiter

Overview:
- Replaces the inline ownership logic for the two resources the ROS2 core shares with the host CPU: the app_data buffer and the UDP RX buffer.
- App_data arbitration is round-robin between the ROS2 core (IP) and the CPU. It adds a per-grant hold watchdog and a configurable dead gap between owners.
- UDP RX buffer ownership is a handoff between IP and CPU, with a CPU notification pulse on each handoff.
- Sits in ros2_ether between the ros2 core's ap_vld strobes and the CPU register interface.

Parameters:
- TIMEOUT_WIDTH, 20, width of the hold counter.
- HOLD_TIMEOUT, 100000, maximum cycles an app_data grant may be held (1 ms at 100 MHz). 0 disables the watchdog. Must be < 2^TIMEOUT_WIDTH.
- GAP_CYCLES, 1, idle cycles forced between a release and the next grant. 0 means no gap.

Ports:
- clk_int  in  1  system clock
- rst_int  in  1  asynchronous active-high reset
- app_data_ip_req  in  1  one-cycle request strobe from ros2 core
- app_data_ip_rel  in  1  one-cycle release strobe from ros2 core
- app_data_cpu_req  in  1  CPU request strobe
- app_data_cpu_rel  in  1  CPU release strobe
- app_data_ip_grant  out  1  app_data owned by ros2 core
- app_data_cpu_grant  out  1  app_data owned by CPU
- udp_rxbuf_ip_rel  in  1  core hands RX buffer to CPU
- udp_rxbuf_cpu_rel  in  1  CPU hands RX buffer back
- udp_rxbuf_ip_grant  out  1  RX buffer owned by core
- udp_rxbuf_cpu_grant  out  1  RX buffer owned by CPU
- udp_rxbuf_cpu_irq  out  1  one-cycle pulse when ownership passes to CPU
- timeout_clr  in  1  clears both sticky timeout flags
- timeout_ip  out  1  sticky: an IP grant was revoked by the watchdog
- timeout_cpu  out  1  sticky: a CPU grant was revoked by the watchdog

Behaviour:

Reset (asynchronous, active-high)
- app FSM enters IDLE; pend_ip = pend_cpu = 0; last_owner = CPU, so IP wins the first tie.
- Rx FSM enters OWN_IP.
- Output reset values: app_data_*_grant = 0, udp_rxbuf_ip_grant = 1, udp_rxbuf_cpu_grant = 0, udp_rxbuf_cpu_irq = 0, timeout_* = 0.
- All outputs are registered.

Request latching
- A req strobe sets pend_x unless x currently holds the grant; in that case it is ignored.
- pend_x is cleared on the edge that grants x.

App FSM states: IDLE, GRANT_IP, GRANT_CPU, GAP
- Grants are one-hot; both grants are never high together.
- IDLE: eff_x = pend_x | req_x.
  - Only one eff set -> grant that requester.
  - Both set -> grant the one that is not last_owner.
  - Latency: req sampled at edge t -> grant high from cycle t+1.
  - rel strobes in IDLE are ignored.
- GRANT_x: the hold counter is cleared on entry and increments each cycle.
  - rel_x -> leave the grant.
  - Otherwise, if HOLD_TIMEOUT != 0 and the counter == HOLD_TIMEOUT-1 -> forced release and timeout_x set. The grant is therefore high for exactly HOLD_TIMEOUT cycles.
  - rel_x and timeout on the same edge count as a normal release; no flag.
  - rel from the non-owner is ignored.
  - On leaving: last_owner = x; go to GAP if GAP_CYCLES > 0, else IDLE.
- GAP: both grants low for exactly GAP_CYCLES cycles, then IDLE. Requests arriving during GAP are latched.
- Back-to-back: with GAP_CYCLES = 0, a rel at edge t and a pending other requester give the other requester its grant from cycle t+2 (one IDLE cycle).

Timeout flags
- timeout_clr clears both flags.
- If timeout_clr and a new timeout event occur on the same edge, the set wins.

Rx FSM states: OWN_IP, OWN_CPU
- OWN_IP + udp_rxbuf_ip_rel -> OWN_CPU, and udp_rxbuf_cpu_irq pulses high for the single cycle after that edge.
- OWN_CPU + udp_rxbuf_cpu_rel -> OWN_IP.
- rel from the non-owner is ignored.
- Both rel strobes asserted together: only the owner's rel acts.
- No watchdog on the RX buffer.

Reset mid-grant
- Grants drop immediately (asynchronously).
- Pending requests are lost; requesters must re-request.

Test Plan:
1. Single request: reset, then app_data_ip_req pulse at cycle 5 -> app_data_ip_grant high from cycle 6. app_data_ip_rel at cycle 10 -> grant low at 11 and GAP for 1 cycle. No other grant before cycle 12.
2. Simultaneous requests: IP and CPU req on the same cycle after reset -> IP granted first, CPU request held pending. After IP rel, CPU is granted after the GAP. Repeat a simultaneous request -> IP is granted next (round-robin).
3. Watchdog: HOLD_TIMEOUT = 16, CPU granted and never releases -> app_data_cpu_grant high exactly 16 cycles, then timeout_cpu = 1 and stays set. timeout_clr pulse -> timeout_cpu = 0.
4. Edge conditions:
   - rel on the exact timeout cycle -> no flag.
   - Owner's req while granted -> ignored, no re-grant after release.
   - Non-owner rel -> no effect.
5. RX buffer handoff:
   - udp_rxbuf_ip_rel -> cpu_grant = 1, ip_grant = 0, and a one-cycle irq.
   - A second ip_rel while in OWN_CPU is ignored.
   - udp_rxbuf_cpu_rel -> returns to OWN_IP with no irq.
6. Reset mid-operation: assert rst_int during an IP grant and OWN_CPU -> outputs return immediately to reset values (rx ip_grant = 1) without waiting for a clock edge.
